// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access sequencer: FSM states, SP update codes,
// access widths and where the saved flags sit inside a 32-bit PC frame.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PUSH2 = 2'b01,
    ST_POP1  = 2'b10,
    ST_POP2  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_RSVD = 2'b11
  } sp_src_t;

  localparam logic MT_16 = 1'b0;
  localparam logic MT_PC = 1'b1;

  // {Z,N,C} ride in PC[31:29]; in the stored high word they land in bits 15:13
  localparam int FLAG_HI = 31;
  localparam int FLAG_LO = 29;

endpackage

// File: rtl/mem_access_unit_sp.sv
// Stack pointer register with modulo inc/dec, wrap detection and the access-address mux
// (push uses SP, pop uses SP+1).
module sp_unit
  import mem_access_unit_pkg::*;
#(
  parameter int                ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] acc_addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] ONE = 1;

  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] sp_dec;

  assign sp_inc   = sp_q + ONE;
  assign sp_dec   = sp_q - ONE;
  assign acc_addr = pop ? sp_inc : sp_q;
  assign wrap     = (push && (sp_q == '0)) || (pop && (sp_q == '1));
  assign sp       = sp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q <= SP_RESET;
    end else if (push) begin
      sp_q <= sp_dec;
    end else if (pop) begin
      sp_q <= sp_inc;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: loads/stores, 16-bit push/pop and two-word PC push/pop on the
// synchronous data memory; stalls upstream while a PC frame transfer is in flight.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int                ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_type_in,
  input  logic [1:0]        SP_src_in,
  input  logic              mem_addr_src_in,
  input  logic              mem_data_src_in,
  input  logic              PC_push_pop_in,
  input  logic              flags_push_pop_in,
  input  logic [31:0]       PC_in,
  input  logic [15:0]       Rdst_val_in,
  input  logic [15:0]       Rsrc_val_in,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [15:0]       dmem_rdata,
  output logic              rd_valid_out,
  output logic              stall_out,
  output logic              ret_valid_out,
  output logic [31:0]       ret_pc_out,
  output logic              is_POP_flags_out,
  output logic [2:0]        POP_flags_val_out,
  output logic              stack_fault_out,
  output logic [ADDR_W-1:0] sp_out
);

  state_t            state;
  state_t            next_state;
  sp_src_t           sp_code;
  logic [15:0]       low_q;
  logic              rd_pend;
  logic              rd_issue;
  logic              idle_req;
  logic              is_wr;
  logic              is_rd;
  logic              idle_push;
  logic              idle_pop;
  logic              wide_push;
  logic              wide_pop;
  logic              sp_push;
  logic              sp_pop;
  logic [ADDR_W-1:0] sp_addr;
  logic              sp_wrap;
  logic              unused_bits;

  // The PC-op tag is implied by mem_type_in; address high bits are dropped
  assign unused_bits = ^{Rsrc_val_in, PC_push_pop_in};

  assign sp_code   = sp_src_t'(SP_src_in);
  assign idle_req  = reset && valid_in && (state == ST_IDLE) && (mem_read_in || mem_write_in);
  assign is_wr     = mem_write_in;
  assign is_rd     = mem_read_in && !mem_write_in;
  assign idle_push = idle_req && (sp_code == SP_PUSH);
  assign idle_pop  = idle_req && (sp_code == SP_POP);
  assign wide_push = idle_push && (mem_type_in == MT_PC) && is_wr;
  assign wide_pop  = idle_pop && (mem_type_in == MT_PC) && is_rd;
  assign sp_push   = idle_push || (state == ST_PUSH2);
  assign sp_pop    = idle_pop || (state == ST_POP1);

  sp_unit #(
    .ADDR_W  (ADDR_W),
    .SP_RESET(SP_RESET)
  ) u_sp (
    .clk     (clk),
    .reset   (reset),
    .push    (sp_push),
    .pop     (sp_pop),
    .sp      (sp_out),
    .acc_addr(sp_addr),
    .wrap    (sp_wrap)
  );

  assign stack_fault_out = sp_wrap;
  assign rd_valid_out    = rd_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      low_q   <= '0;
      rd_pend <= 1'b0;
    end else begin
      state   <= next_state;
      rd_pend <= rd_issue;
      if (state == ST_POP1) begin
        low_q <= dmem_rdata;
      end
    end
  end

  always_comb begin
    next_state        = state;
    dmem_addr         = '0;
    dmem_wdata        = '0;
    dmem_we           = 1'b0;
    dmem_re           = 1'b0;
    stall_out         = 1'b0;
    ret_valid_out     = 1'b0;
    ret_pc_out        = '0;
    is_POP_flags_out  = 1'b0;
    POP_flags_val_out = '0;
    rd_issue          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (idle_req) begin
          dmem_addr = (mem_addr_src_in || wide_push || wide_pop) ? sp_addr
                                                                 : Rsrc_val_in[ADDR_W-1:0];
          dmem_we   = is_wr;
          dmem_re   = is_rd;
          if (wide_push) begin
            dmem_wdata = {(flags_push_pop_in ? PC_in[FLAG_HI:FLAG_LO] : 3'b000), PC_in[28:16]};
            stall_out  = 1'b1;
            next_state = ST_PUSH2;
          end else if (wide_pop) begin
            stall_out  = 1'b1;
            next_state = ST_POP1;
          end else begin
            dmem_wdata = is_wr ? (mem_data_src_in ? Rsrc_val_in : Rdst_val_in) : 16'h0000;
            rd_issue   = is_rd;
          end
        end
      end
      ST_PUSH2: begin
        dmem_addr  = sp_addr;
        dmem_we    = 1'b1;
        dmem_wdata = PC_in[15:0];
        next_state = ST_IDLE;
      end
      ST_POP1: begin
        dmem_addr  = sp_addr;
        dmem_re    = 1'b1;
        stall_out  = 1'b1;
        next_state = ST_POP2;
      end
      ST_POP2: begin
        // High word arrives now; low half was captured in POP1
        ret_valid_out     = 1'b1;
        ret_pc_out        = {3'b000, dmem_rdata[12:0], low_q};
        is_POP_flags_out  = flags_push_pop_in;
        POP_flags_val_out = dmem_rdata[15:13];
        next_state        = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural synchronous memory.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        mem_type_in;
  logic [1:0]  SP_src_in;
  logic        mem_addr_src_in;
  logic        mem_data_src_in;
  logic        PC_push_pop_in;
  logic        flags_push_pop_in;
  logic [31:0] PC_in;
  logic [15:0] Rdst_val_in;
  logic [15:0] Rsrc_val_in;
  logic [10:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [15:0] dmem_rdata;
  logic        rd_valid_out;
  logic        stall_out;
  logic        ret_valid_out;
  logic [31:0] ret_pc_out;
  logic        is_POP_flags_out;
  logic [2:0]  POP_flags_val_out;
  logic        stack_fault_out;
  logic [10:0] sp_out;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.ADDR_W(11)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_in         (valid_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .mem_type_in      (mem_type_in),
    .SP_src_in        (SP_src_in),
    .mem_addr_src_in  (mem_addr_src_in),
    .mem_data_src_in  (mem_data_src_in),
    .PC_push_pop_in   (PC_push_pop_in),
    .flags_push_pop_in(flags_push_pop_in),
    .PC_in            (PC_in),
    .Rdst_val_in      (Rdst_val_in),
    .Rsrc_val_in      (Rsrc_val_in),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_we          (dmem_we),
    .dmem_re          (dmem_re),
    .dmem_rdata       (dmem_rdata),
    .rd_valid_out     (rd_valid_out),
    .stall_out        (stall_out),
    .ret_valid_out    (ret_valid_out),
    .ret_pc_out       (ret_pc_out),
    .is_POP_flags_out (is_POP_flags_out),
    .POP_flags_val_out(POP_flags_val_out),
    .stack_fault_out  (stack_fault_out),
    .sp_out           (sp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:2047];
  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
    if (dmem_re) dmem_rdata <= mem[dmem_addr];
  end

  typedef struct {
    logic        valid, rd, wr;
    logic [1:0]  sps;
    logic        asrc, dsrc;
    logic [15:0] rdst, rsrc;
    logic        e_we, e_re;
    logic [10:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_fault;
    logic [10:0] e_sp;
    logic        e_rdv, ck_dat;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(logic valid, logic rd, logic wr, logic [1:0] sps, logic asrc,
                              logic dsrc, logic [15:0] rdst, logic [15:0] rsrc, logic e_we,
                              logic e_re, logic [10:0] e_addr, logic [15:0] e_wdata,
                              logic e_fault, logic [10:0] e_sp, logic e_rdv, logic ck_dat,
                              logic [15:0] e_rdata);
    vec_t v;
    v.valid = valid; v.rd = rd; v.wr = wr; v.sps = sps; v.asrc = asrc; v.dsrc = dsrc;
    v.rdst = rdst; v.rsrc = rsrc; v.e_we = e_we; v.e_re = e_re; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_fault = e_fault; v.e_sp = e_sp; v.e_rdv = e_rdv;
    v.ck_dat = ck_dat; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    valid_in = 0; mem_read_in = 0; mem_write_in = 0; mem_type_in = 0; SP_src_in = 2'b00;
    mem_addr_src_in = 0; mem_data_src_in = 0; PC_push_pop_in = 0; flags_push_pop_in = 0;
    PC_in = 32'h0; Rdst_val_in = 16'h0; Rsrc_val_in = 16'h0;
  endtask

  initial begin
    reset = 1'b0;
    idle_in();

    //            vld rd wr sps  as ds rdst      rsrc      we re addr    wdata     flt sp      rdv ck rdata
    vt[0]  = mk(1, 1, 0, 2'b00, 0, 0, 16'h0000, 16'h0010, 0, 1, 11'h010, 16'h0000, 0, 11'h7FF, 1, 0, 16'h0000);
    vt[1]  = mk(1, 0, 1, 2'b00, 0, 0, 16'h5A5A, 16'h0010, 1, 0, 11'h010, 16'h5A5A, 0, 11'h7FF, 0, 0, 16'h0000);
    vt[2]  = mk(1, 1, 0, 2'b00, 0, 0, 16'h0000, 16'h0810, 0, 1, 11'h010, 16'h0000, 0, 11'h7FF, 1, 1, 16'h5A5A);
    vt[3]  = mk(1, 0, 1, 2'b00, 0, 1, 16'h9999, 16'h0030, 1, 0, 11'h030, 16'h0030, 0, 11'h7FF, 0, 0, 16'h0000);
    vt[4]  = mk(1, 1, 1, 2'b00, 0, 0, 16'h2222, 16'h0040, 1, 0, 11'h040, 16'h2222, 0, 11'h7FF, 0, 0, 16'h0000);
    vt[5]  = mk(1, 1, 0, 2'b00, 0, 0, 16'h0000, 16'h0040, 0, 1, 11'h040, 16'h0000, 0, 11'h7FF, 1, 1, 16'h2222);
    vt[6]  = mk(0, 1, 0, 2'b00, 0, 0, 16'h0000, 16'h0040, 0, 0, 11'h000, 16'h0000, 0, 11'h7FF, 0, 0, 16'h0000);
    vt[7]  = mk(1, 0, 0, 2'b01, 1, 0, 16'h1234, 16'h0000, 0, 0, 11'h000, 16'h0000, 0, 11'h7FF, 0, 0, 16'h0000);
    vt[8]  = mk(1, 0, 1, 2'b01, 1, 0, 16'hBEEF, 16'h0000, 1, 0, 11'h7FF, 16'hBEEF, 0, 11'h7FE, 0, 0, 16'h0000);
    vt[9]  = mk(1, 1, 0, 2'b10, 1, 0, 16'h0000, 16'h0000, 0, 1, 11'h7FF, 16'h0000, 0, 11'h7FF, 1, 1, 16'hBEEF);
    vt[10] = mk(1, 0, 1, 2'b11, 0, 0, 16'h3333, 16'h0050, 1, 0, 11'h050, 16'h3333, 0, 11'h7FF, 0, 0, 16'h0000);
    vt[11] = mk(1, 1, 0, 2'b00, 0, 0, 16'h0000, 16'h0050, 0, 1, 11'h050, 16'h0000, 0, 11'h7FF, 1, 1, 16'h3333);
    vt[12] = mk(1, 1, 0, 2'b10, 1, 0, 16'h0000, 16'h0000, 0, 1, 11'h000, 16'h0000, 1, 11'h000, 1, 0, 16'h0000);
    vt[13] = mk(1, 0, 1, 2'b01, 1, 0, 16'hCAFE, 16'h0000, 1, 0, 11'h000, 16'hCAFE, 1, 11'h7FF, 0, 0, 16'h0000);
    vt[14] = mk(1, 1, 0, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 1, 11'h000, 16'h0000, 0, 11'h7FF, 1, 1, 16'hCAFE);
    vt[15] = mk(1, 1, 0, 2'b00, 0, 0, 16'h0000, 16'h0030, 0, 1, 11'h030, 16'h0000, 0, 11'h7FF, 1, 1, 16'h0030);

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst sp", 32'(sp_out), 32'h7FF);
    chk("rst strobes", {28'h0, dmem_we, dmem_re, stall_out, ret_valid_out}, 32'h0);
    chk("rst pulses", {29'h0, stack_fault_out, rd_valid_out, is_POP_flags_out}, 32'h0);
    reset = 1'b1;

    // Single-cycle 16-bit operations
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle_in();
      valid_in = vt[i].valid; mem_read_in = vt[i].rd; mem_write_in = vt[i].wr;
      SP_src_in = vt[i].sps; mem_addr_src_in = vt[i].asrc; mem_data_src_in = vt[i].dsrc;
      Rdst_val_in = vt[i].rdst; Rsrc_val_in = vt[i].rsrc;
      #2;
      chk($sformatf("v%0d we", i), 32'(dmem_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d re", i), 32'(dmem_re), 32'(vt[i].e_re));
      chk($sformatf("v%0d fault", i), 32'(stack_fault_out), 32'(vt[i].e_fault));
      chk($sformatf("v%0d stall", i), {31'h0, stall_out}, 32'h0);
      if (vt[i].e_we || vt[i].e_re) chk($sformatf("v%0d addr", i), 32'(dmem_addr), 32'(vt[i].e_addr));
      if (vt[i].e_we) chk($sformatf("v%0d wdata", i), 32'(dmem_wdata), 32'(vt[i].e_wdata));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d sp", i), 32'(sp_out), 32'(vt[i].e_sp));
      chk($sformatf("v%0d rdv", i), 32'(rd_valid_out), 32'(vt[i].e_rdv));
      if (vt[i].ck_dat) chk($sformatf("v%0d rdata", i), 32'(dmem_rdata), 32'(vt[i].e_rdata));
    end

    // CALL: two-word PC push with flags
    @(negedge clk);
    idle_in();
    valid_in = 1; mem_write_in = 1; mem_type_in = 1; SP_src_in = 2'b01; mem_addr_src_in = 1;
    PC_push_pop_in = 1; flags_push_pop_in = 1; PC_in = 32'hA000_1234;
    #2;
    chk("call0 we", 32'(dmem_we), 32'h1);
    chk("call0 addr", 32'(dmem_addr), 32'h7FF);
    chk("call0 wdata", 32'(dmem_wdata), 32'hA000);
    chk("call0 stall", 32'(stall_out), 32'h1);
    @(negedge clk);
    #2;
    chk("call1 we", 32'(dmem_we), 32'h1);
    chk("call1 addr", 32'(dmem_addr), 32'h7FE);
    chk("call1 wdata", 32'(dmem_wdata), 32'h1234);
    chk("call1 stall", 32'(stall_out), 32'h0);
    @(negedge clk);
    idle_in();
    #2;
    chk("call sp", 32'(sp_out), 32'h7FD);
    chk("call idle we", 32'(dmem_we), 32'h0);

    // RTI: two-word PC pop with flags
    @(negedge clk);
    valid_in = 1; mem_read_in = 1; mem_type_in = 1; SP_src_in = 2'b10; mem_addr_src_in = 1;
    PC_push_pop_in = 1; flags_push_pop_in = 1;
    #2;
    chk("rti0 re", 32'(dmem_re), 32'h1);
    chk("rti0 addr", 32'(dmem_addr), 32'h7FE);
    chk("rti0 stall", 32'(stall_out), 32'h1);
    @(negedge clk);
    #2;
    chk("rti1 re", 32'(dmem_re), 32'h1);
    chk("rti1 addr", 32'(dmem_addr), 32'h7FF);
    chk("rti1 stall", 32'(stall_out), 32'h1);
    chk("rti1 retv", 32'(ret_valid_out), 32'h0);
    @(negedge clk);
    #2;
    chk("rti2 retv", 32'(ret_valid_out), 32'h1);
    chk("rti2 pc", ret_pc_out, 32'h0000_1234);
    chk("rti2 isflags", 32'(is_POP_flags_out), 32'h1);
    chk("rti2 flags", 32'(POP_flags_val_out), 32'h5);
    chk("rti2 stall", 32'(stall_out), 32'h0);
    chk("rti2 re", 32'(dmem_re), 32'h0);
    @(negedge clk);
    idle_in();
    #2;
    chk("rti sp", 32'(sp_out), 32'h7FF);
    chk("rti idle retv", 32'(ret_valid_out), 32'h0);

    // Reset asserted while in POP1
    @(negedge clk);
    valid_in = 1; mem_read_in = 1; mem_type_in = 1; SP_src_in = 2'b10; mem_addr_src_in = 1;
    #2;
    chk("rp0 addr", 32'(dmem_addr), 32'h000);
    chk("rp0 fault", 32'(stack_fault_out), 32'h1);
    @(negedge clk);
    #2;
    chk("rp1 stall", 32'(stall_out), 32'h1);
    reset = 1'b0;
    #1;
    chk("rp rst stall", 32'(stall_out), 32'h0);
    chk("rp rst sp", 32'(sp_out), 32'h7FF);
    chk("rp rst re", 32'(dmem_re), 32'h0);
    chk("rp rst retv", 32'(ret_valid_out), 32'h0);
    @(negedge clk);
    idle_in();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      chk($sformatf("rp post%0d retv", c), 32'(ret_valid_out), 32'h0);
      chk($sformatf("rp post%0d stall", c), 32'(stall_out), 32'h0);
      chk($sformatf("rp post%0d sp", c), 32'(sp_out), 32'h7FF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
